// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC source selection, PR1 pipeline register,
// squash-pulse generation for downstream pipeline registers, a sticky
// illegal-select flag and a saturating accepted-instruction counter.
//
// Next-PC source codes on pc_mux_select:
//   0 = PC+1
//   1 = rb  : rb_val   (JLR target, resolved in PR3)   -> squash PR1, PR2
//   2 = c   : mem_val  (R7 load data, resolved in PR5) -> squash PR1..PR4
//   3 = m   : pr2_tgt  (JAL target, resolved in PR2)   -> squash PR1
//   4 = one : pr3_tgt  (BEQ target, resolved in PR3)   -> squash PR1, PR2
//   5 = h   : lhi_val  (LHI result, resolved in PR2)   -> squash PR1
//   6 = a   : alu_val  (R7 ALU result, in PR4)         -> squash PR1..PR3
//   7 = illegal, treated as PC+1 and latched into sel_err
module fetch_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  pc_mux_select,
   input  logic        stall,
   input  logic [15:0] rb_val,
   input  logic [15:0] mem_val,
   input  logic [15:0] pr2_tgt,
   input  logic [15:0] pr3_tgt,
   input  logic [15:0] lhi_val,
   input  logic [15:0] alu_val,
   input  logic [15:0] imem_data,
   output logic [15:0] imem_addr,
   output logic [15:0] pr1_IR,
   output logic [15:0] pr1_PC,
   output logic        pr1_valid,
   output logic        flush_pr2,
   output logic        flush_pr3,
   output logic        flush_pr4,
   output logic        sel_err,
   output logic [15:0] fetch_cnt
);

   typedef enum logic [2:0] {
      SEL_INC  = 3'd0,
      SEL_RB   = 3'd1,
      SEL_C    = 3'd2,
      SEL_M    = 3'd3,
      SEL_ONE  = 3'd4,
      SEL_H    = 3'd5,
      SEL_A    = 3'd6,
      SEL_ILL  = 3'd7
   } sel_t;

   sel_t        sel;
   logic [15:0] pc;

   // Combinational results for the coming edge
   logic        redirect;
   logic [15:0] target;
   logic        sq_pr2;
   logic        sq_pr3;
   logic        sq_pr4;
   logic        advance;
   logic [15:0] pc_next;
   logic [15:0] pr1_ir_next;
   logic [15:0] pr1_pc_next;
   logic        pr1_valid_next;
   logic [15:0] fetch_cnt_next;
   logic        sel_err_next;

   assign sel       = sel_t'(pc_mux_select);
   assign imem_addr = pc;

   // Decode the select code into a redirect target and its squash depth
   always_comb begin
      redirect = 1'b0;
      target   = 16'h0000;
      sq_pr2   = 1'b0;
      sq_pr3   = 1'b0;
      sq_pr4   = 1'b0;
      case (sel)
         SEL_RB: begin
            redirect = 1'b1;
            target   = rb_val;
            sq_pr2   = 1'b1;
         end
         SEL_C: begin
            redirect = 1'b1;
            target   = mem_val;
            sq_pr2   = 1'b1;
            sq_pr3   = 1'b1;
            sq_pr4   = 1'b1;
         end
         SEL_M: begin
            redirect = 1'b1;
            target   = pr2_tgt;
         end
         SEL_ONE: begin
            redirect = 1'b1;
            target   = pr3_tgt;
            sq_pr2   = 1'b1;
         end
         SEL_H: begin
            redirect = 1'b1;
            target   = lhi_val;
         end
         SEL_A: begin
            redirect = 1'b1;
            target   = alu_val;
            sq_pr2   = 1'b1;
            sq_pr3   = 1'b1;
         end
         default: begin
            // PC+1 and the illegal code both fall through to sequential fetch
            redirect = 1'b0;
         end
      endcase
   end

   // Next-state for PC, PR1, the counter and the error flag.
   // A redirect wins over stall; a plain stall freezes PC and PR1.
   always_comb begin
      advance        = !redirect && !stall;
      pc_next        = pc;
      pr1_ir_next    = pr1_IR;
      pr1_pc_next    = pr1_PC;
      pr1_valid_next = pr1_valid;
      fetch_cnt_next = fetch_cnt;
      sel_err_next   = sel_err || (sel == SEL_ILL);

      if (redirect) begin
         pc_next        = target;
         pr1_ir_next    = 16'h0000;
         pr1_pc_next    = pc;
         pr1_valid_next = 1'b0;
      end else if (advance) begin
         pc_next        = pc + 16'd1;
         pr1_ir_next    = imem_data;
         pr1_pc_next    = pc;
         pr1_valid_next = 1'b1;
         if (fetch_cnt != 16'hFFFF) begin
            fetch_cnt_next = fetch_cnt + 16'd1;
         end
      end
   end

   // PC and PR1 registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc        <= 16'h0000;
         pr1_IR    <= 16'h0000;
         pr1_PC    <= 16'h0000;
         pr1_valid <= 1'b0;
      end else begin
         pc        <= pc_next;
         pr1_IR    <= pr1_ir_next;
         pr1_PC    <= pr1_pc_next;
         pr1_valid <= pr1_valid_next;
      end
   end

   // Flush pulses: loaded every edge so they last exactly one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flush_pr2 <= 1'b0;
         flush_pr3 <= 1'b0;
         flush_pr4 <= 1'b0;
      end else begin
         flush_pr2 <= sq_pr2;
         flush_pr3 <= sq_pr3;
         flush_pr4 <= sq_pr4;
      end
   end

   // Accepted-instruction counter and sticky illegal-select flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt <= 16'h0000;
         sel_err   <= 1'b0;
      end else begin
         fetch_cnt <= fetch_cnt_next;
         sel_err   <= sel_err_next;
      end
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: pc_mux_select  in  3  next-PC source code, stable by rising edge: 0=PC+1, 1=rb, 2=c, 3=m, 4=one, 5=h, 6=a, 7=illegal.
REQ-004 SHALL provide: stall  in  1  hazard hold request from decode.
REQ-005 SHALL provide: rb_val  in  16  JLR target (RFout2 of PR3).
REQ-006 SHALL provide: mem_val  in  16  LW/LM load data for R7 (PR5).
REQ-007 SHALL provide: pr2_tgt  in  16  JAL target PC+Im6 (PR2).
REQ-008 SHALL provide: pr3_tgt  in  16  BEQ target PC+Im6 (PR3).
REQ-009 SHALL provide: lhi_val  in  16  LHI result {Im9,7'b0} (PR2).
REQ-010 SHALL provide: alu_val  in  16  ALU result for R7 (PR4).
REQ-011 SHALL provide: imem_data  in  16  combinational instruction-memory read data.
REQ-012 SHALL provide: imem_addr  out  16  instruction-memory address, equal to the PC register.
REQ-013 SHALL provide: pr1_IR, pr1_PC  out  16 each  fetched instruction and its address.
REQ-014 SHALL provide: pr1_valid  out  1  PR1 holds a live instruction.
REQ-015 SHALL provide: flush_pr2, flush_pr3, flush_pr4  out  1 each  one-cycle squash pulses to downstream pipeline registers.
REQ-016 SHALL provide: sel_err  out  1  sticky illegal-select flag.
REQ-017 SHALL provide: fetch_cnt  out  16  count of instructions accepted into PR1.

Function
REQ-018 PC SHALL be a 16-bit register; imem_addr SHALL equal PC combinationally.
REQ-019 A redirect SHALL be any pc_mux_select in 1..6; on a redirect edge, PC SHALL load the selected source value.
REQ-020 Without a redirect or stall, PC SHALL load PC+1 modulo 2^16; 16'hFFFF SHALL wrap to 16'h0000.
REQ-021 With stall=1 and no redirect, PC, pr1_IR, pr1_PC and pr1_valid SHALL hold.
REQ-022 A redirect SHALL override stall in the same cycle.
REQ-023 On a non-stalled, non-redirect edge, PR1 SHALL load pr1_IR=imem_data, pr1_PC=PC and pr1_valid=1, and fetch_cnt SHALL increment, saturating at 16'hFFFF.
REQ-024 On a redirect edge, pr1_valid SHALL clear, pr1_IR SHALL load 16'h0000, and fetch_cnt SHALL not increment.
REQ-025 Squash depth by source on a redirect edge: m or h SHALL squash PR1 only; one or rb SHALL additionally pulse flush_pr2; a SHALL pulse flush_pr2 and flush_pr3; c SHALL pulse flush_pr2, flush_pr3 and flush_pr4.
REQ-026 Flush outputs SHALL be registered, SHALL assert for exactly the cycle after the redirect edge, and SHALL be 0 otherwise.
REQ-027 After a redirect, a second redirect on the next edge SHALL be honoured normally; the new target SHALL take effect and the flush pulses SHALL be recomputed from the new source.
REQ-028 pc_mux_select=7 SHALL behave as 0 (PC+1 rules) and SHALL set sel_err, which remains 1 until reset.
REQ-029 Latency: a redirect sampled at edge N SHALL present the target on imem_addr after edge N; that instruction SHALL be valid in PR1 after edge N+1.

Reset
REQ-030 While reset=0, asynchronously: PC=0, pr1_IR=0, pr1_PC=0, pr1_valid=0, all flush outputs=0, sel_err=0, fetch_cnt=0.
REQ-031 On the first rising edge after reset deasserts, the block SHALL fetch address 0 and accept it into PR1 unless stalled or redirected.
REQ-032 Reset asserted mid-redirect or mid-stall SHALL abandon the operation; no flush pulse SHALL survive reset.

Verification
REQ-033 Reset release with select=0, stall=0, imem_data=addr^16'hA5A5 for 3 edges -> pr1_PC=0,1,2 in turn; pr1_valid=1; fetch_cnt=3.
REQ-034 PC=16'hFFFF with select=0 -> next imem_addr=16'h0000; pr1_PC=16'hFFFF.
REQ-035 stall=1 with select=4, pr3_tgt=16'h0040 -> PC=16'h0040; pr1_valid=0; flush_pr2=1 for 1 cycle; flush_pr3=flush_pr4=0.
REQ-036 select=2, mem_val=16'h1234 -> PC=16'h1234; flush_pr2=flush_pr3=flush_pr4=1 for 1 cycle; fetch_cnt unchanged.
REQ-037 select=7 for one edge, then 0 -> PC advances by 1 each edge; sel_err=1 and held until reset=0.
REQ-038 select=6 then reset=0 asserted before the next edge -> all outputs immediately at reset values; no flush pulse after release.
